uart_parity_unit: RTL and testbench
===================================

UART_PARITY_UNIT -- requirements
Module: uart_parity_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, maximum data word width in bits (legal range 5-9).
REQ-002 SHALL have parameter CNT_W, default 8, width of the parity-error counter.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port mode, input, 3 bits; parity mode: 000 none, 001 even, 010 odd, 011 mark, 100 space, 101-111 treated as none.
REQ-006 SHALL have port data, input, WIDTH bits; data word, LSB first.
REQ-007 SHALL have port data_len, input, 4 bits; number of valid data bits, counted from the LSB.
REQ-008 SHALL have port chk_en, input, 1 bit; 1 selects check (receiver) operation, 0 selects generate-only operation.
REQ-009 SHALL have port rx_par, input, 1 bit; received parity bit, used only when chk_en=1.
REQ-010 SHALL have port in_valid, input, 1 bit; an input word is presented.
REQ-011 SHALL have port in_ready, output, 1 bit; the unit can accept a word.
REQ-012 SHALL have port out_valid, output, 1 bit; the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit; the downstream consumer accepts the result.
REQ-014 SHALL have port p_out, output, 1 bit; the computed parity bit.
REQ-015 SHALL have port p_err, output, 1 bit; parity mismatch flag for the current result.
REQ-016 SHALL have port err_clr, input, 1 bit; clears err_cnt.
REQ-017 SHALL have port err_cnt, output, CNT_W bits; saturating count of parity errors.

Function
REQ-018 SHALL implement FSM states IDLE, CALC and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE; an accept occurs on any edge where in_valid=1 and in_ready=1.
REQ-020 SHALL, on accept, capture data, mode, chk_en and rx_par, and capture the effective length L (data_len, or WIDTH when data_len is 0 or greater than WIDTH); then go to CALC.
REQ-021 SHALL, in CALC, shift the captured data LSB first, one bit per cycle, XOR-accumulating for exactly L cycles; then go to DONE.
REQ-022 SHALL assert out_valid exactly L+1 rising edges after the accepting edge.
REQ-023 SHALL set p_out in DONE as follows: even = XOR of the L bits; odd = inverted XOR of the L bits; mark = 1; space = 0; none = 0.
REQ-024 SHALL set p_err=1 in DONE only when chk_en=1, mode is not none, and rx_par differs from p_out; otherwise p_err=0.
REQ-025 SHALL increment err_cnt by 1 on the edge entering DONE when p_err is set, saturating at 2^CNT_W-1 without wrapping.
REQ-026 SHALL give err_clr priority: when err_clr and an increment occur on the same edge, err_cnt becomes 0.
REQ-027 SHALL hold out_valid, p_out and p_err stable in DONE until out_ready=1; on out_valid=1 and out_ready=1, go to IDLE and clear out_valid.
REQ-028 SHALL ignore in_valid, mode, data and rx_par changes while in CALC or DONE; no accept occurs in the same cycle as the DONE handshake.
REQ-029 SHALL keep p_out and p_err at their DONE values after the handshake until the next DONE.

Reset
REQ-030 SHALL, when rst=1 on a rising edge (in any state, including mid-CALC), go to IDLE and set out_valid=0, p_out=0, p_err=0, err_cnt=0; in_ready is 1 on the following cycle.
REQ-031 SHALL give rst priority over all other inputs, including err_clr and handshakes.

Verification
REQ-032 SHALL verify even parity (WIDTH=8): mode=001, data=8'hA5, data_len=8 -> p_out=0 and out_valid exactly 9 edges after accept.
REQ-033 SHALL verify short length: mode=001, data=8'hFF, data_len=5 -> p_out=1 and out_valid 6 edges after accept; then mode=010 with the same data -> p_out=0.
REQ-034 SHALL verify check operation: mode=001, chk_en=1, data=8'h01, rx_par=0 -> p_err=1 and err_cnt=1; then rx_par=1 -> p_err=0 and err_cnt stays 1.
REQ-035 SHALL verify backpressure: out_ready held at 0 for 5 cycles in DONE -> out_valid, p_out and p_err stable, in_ready=0, and toggling in_valid has no effect.
REQ-036 SHALL verify reset mid-operation: rst pulsed during the 3rd CALC cycle -> next cycle out_valid=0, err_cnt=0, in_ready=1.
REQ-037 SHALL verify counter saturation and clear (CNT_W=2): 4 error words -> err_cnt=3; a 5th error coinciding with err_clr -> err_cnt=0.

Source files
------------

// File: rtl/uart_parity_unit.sv
// uart_parity_unit
//
// Bit-serial UART parity generator / checker. A data word is accepted in
// IDLE, its effective number of bits is XOR-accumulated one bit per cycle in
// CALC, and the parity result is presented in DONE until the consumer takes
// it. In check mode the received parity bit is compared against the computed
// one. Parity errors are counted in a saturating counter.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   mode      - 000 none, 001 even, 010 odd, 011 mark, 100 space, else none
//   data      - data word, LSB first
//   data_len  - number of valid data bits (0 or > WIDTH means WIDTH)
//   chk_en    - 1 = check received parity, 0 = generate only
//   rx_par    - received parity bit (check mode only)
//   in_valid  - input word presented
//   in_ready  - unit can accept a word (IDLE only)
//   out_valid - result valid (DONE)
//   out_ready - consumer accepts the result
//   p_out     - computed parity bit
//   p_err     - parity mismatch flag
//   err_clr   - clear the error counter
//   err_cnt   - saturating parity error count

module uart_parity_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       data_len,
    input  logic             chk_en,
    input  logic             rx_par,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             p_out,
    output logic             p_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] WIDTH_L = 4'(WIDTH);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   data_q,    data_d;
    logic [2:0]         mode_q,    mode_d;
    logic               chk_q,     chk_d;
    logic               rx_par_q,  rx_par_d;
    logic [3:0]         cnt_q,     cnt_d;
    logic               acc_q,     acc_d;
    logic               p_out_q,   p_out_d;
    logic               p_err_q,   p_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [3:0]         eff_len;
    logic               par_calc;
    logic               par_active;
    logic               err_calc;

    // A length of zero or one beyond the data word means "use the full word".
    always_comb begin
        eff_len = data_len;
        if (data_len == 4'd0 || data_len > WIDTH_L) begin
            eff_len = WIDTH_L;
        end
    end

    // Final parity from the accumulated XOR and the captured mode. Modes
    // 101-111 behave exactly like "none".
    always_comb begin
        par_calc   = 1'b0;
        par_active = 1'b1;
        case (mode_q)
            3'b001:  par_calc = acc_q;
            3'b010:  par_calc = ~acc_q;
            3'b011:  par_calc = 1'b1;
            3'b100:  par_calc = 1'b0;
            default: begin
                par_calc   = 1'b0;
                par_active = 1'b0;
            end
        endcase
        err_calc = chk_q && par_active && (rx_par_q != par_calc);
    end

    // Next-state logic. CALC spends one cycle per valid bit and one more
    // cycle once the bit counter reaches zero to latch the result, so the
    // result appears L+1 edges after the accepting edge.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mode_d    = mode_q;
        chk_d     = chk_q;
        rx_par_d  = rx_par_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        p_out_d   = p_out_q;
        p_err_d   = p_err_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d   = data;
                    mode_d   = mode;
                    chk_d    = chk_en;
                    rx_par_d = rx_par;
                    cnt_d    = eff_len;
                    acc_d    = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q != 4'd0) begin
                    acc_d  = acc_q ^ data_q[0];
                    data_d = data_q >> 1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    p_out_d = par_calc;
                    p_err_d = err_calc;
                    if (err_calc && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear wins over a same-edge increment.
        if (err_clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mode_q    <= '0;
            chk_q     <= 1'b0;
            rx_par_q  <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            p_out_q   <= 1'b0;
            p_err_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            mode_q    <= mode_d;
            chk_q     <= chk_d;
            rx_par_q  <= rx_par_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            p_out_q   <= p_out_d;
            p_err_q   <= p_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign p_out     = p_out_q;
    assign p_err     = p_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_parity_unit.sv
// tb_uart_parity_unit
//
// Scoreboard bench for uart_parity_unit (WIDTH=8, CNT_W=2). Each stimulus
// word pushes its expected parity, error flag and latency onto a queue; the
// entry is popped and compared when the DUT raises out_valid. Inputs are
// driven and outputs sampled on the falling clock edge.

module tb_uart_parity_unit;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data;
    logic [3:0]       data_len;
    logic             chk_en;
    logic             rx_par;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             p_out;
    logic             p_err;
    logic             err_clr;
    logic [CNT_W-1:0] err_cnt;

    typedef struct {
        logic par;
        logic err;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    uart_parity_unit #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .data     (data),
        .data_len (data_len),
        .chk_en   (chk_en),
        .rx_par   (rx_par),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p_out    (p_out),
        .p_err    (p_err),
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference model of the parity computation.
    function automatic exp_t model(input logic [2:0] m, input logic [7:0] d,
                                   input logic [3:0] len, input logic chk, input logic rx);
        exp_t e;
        int   l;
        logic x;
        logic active;
        l = (len == 4'd0 || int'(len) > WIDTH) ? WIDTH : int'(len);
        x = 1'b0;
        for (int i = 0; i < l; i++) begin
            x = x ^ d[i];
        end
        active = 1'b1;
        case (m)
            3'd1:    e.par = x;
            3'd2:    e.par = ~x;
            3'd3:    e.par = 1'b1;
            3'd4:    e.par = 1'b0;
            default: begin
                e.par  = 1'b0;
                active = 1'b0;
            end
        endcase
        e.err = chk && active && (rx != e.par);
        e.lat = l + 1;
        return e;
    endfunction

    // Drives one word, waits for the result, checks it against the
    // scoreboard, holds off the consumer for 'hold' cycles, then hands off.
    task automatic applyStimulus(input string tag, input logic [2:0] m, input logic [7:0] d,
                                 input logic [3:0] len, input logic chk, input logic rx,
                                 input int hold, input logic clr_on_done);
        exp_t e;
        int   lat;
        int   want_lat;
        logic done;

        mode     = m;
        data     = d;
        data_len = len;
        chk_en   = chk;
        rx_par   = rx;
        in_valid = 1'b1;
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        sb.push_back(model(m, d, len, chk, rx));
        want_lat = sb[$].lat;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // Captured inputs must be immune to later changes.
        data     = ~d;
        rx_par   = ~rx;
        mode     = 3'd3;
        data_len = 4'd1;

        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            err_clr = clr_on_done && (lat == want_lat - 1);
            @(posedge clk);
            lat++;
            @(negedge clk);
            err_clr = 1'b0;
            if (out_valid) done = 1'b1;
        end

        e = sb.pop_front();
        if (!done) begin
            checkOutput({tag, ".timeout"}, 32'd0, 32'd1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst     = 1'b0;
            exp_cnt = 0;
            return;
        end

        checkOutput({tag, ".latency"}, 32'(lat), 32'(e.lat));
        checkOutput({tag, ".p_out"},   32'(p_out), 32'(e.par));
        checkOutput({tag, ".p_err"},   32'(p_err), 32'(e.err));
        if (clr_on_done)                     exp_cnt = 0;
        else if (e.err && exp_cnt < CNT_MAX) exp_cnt++;
        checkOutput({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));

        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            data     = 8'($urandom);
            mode     = 3'($urandom_range(0, 7));
            rx_par   = ~rx_par;
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".hold_p_out"}, 32'(p_out),     32'(e.par));
            checkOutput({tag, ".hold_p_err"}, 32'(p_err),     32'(e.err));
            checkOutput({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
        end

        // Handshake with in_valid high: no accept may occur on this edge.
        in_valid  = (hold > 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".post_ready"}, 32'(in_ready),  32'd1);
        checkOutput({tag, ".post_p_out"}, 32'(p_out),     32'(e.par));
        checkOutput({tag, ".post_p_err"}, 32'(p_err),     32'(e.err));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 3'd0;
        data      = '0;
        data_len  = 4'd0;
        chk_en    = 1'b0;
        rx_par    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.p_out",     32'(p_out),     32'd0);
        checkOutput("reset.p_err",     32'(p_err),     32'd0);
        checkOutput("reset.err_cnt",   32'(err_cnt),   32'd0);

        // Even/odd and short lengths.
        applyStimulus("even_a5",   3'd1, 8'hA5, 4'd8,  1'b0, 1'b0, 0, 1'b0);
        applyStimulus("even_ff5",  3'd1, 8'hFF, 4'd5,  1'b0, 1'b0, 0, 1'b0);
        applyStimulus("odd_ff5",   3'd2, 8'hFF, 4'd5,  1'b0, 1'b0, 0, 1'b0);
        applyStimulus("odd_len0",  3'd2, 8'h07, 4'd0,  1'b0, 1'b0, 0, 1'b0);
        applyStimulus("even_len12",3'd1, 8'h80, 4'd12, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("even_len1", 3'd1, 8'h03, 4'd1,  1'b0, 1'b0, 0, 1'b0);

        // Constant modes and "none" aliases, checked against mismatching rx.
        applyStimulus("mark_chk",  3'd3, 8'h00, 4'd7,  1'b1, 1'b0, 0, 1'b0);
        applyStimulus("space_chk", 3'd4, 8'hFF, 4'd8,  1'b1, 1'b1, 0, 1'b0);
        applyStimulus("none_chk",  3'd0, 8'h01, 4'd8,  1'b1, 1'b1, 0, 1'b0);
        applyStimulus("m7_chk",    3'd7, 8'h01, 4'd8,  1'b1, 1'b1, 0, 1'b0);

        // Standalone clear in IDLE.
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr = 1'b0;
        exp_cnt = 0;
        checkOutput("clr_idle.err_cnt", 32'(err_cnt), 32'd0);

        // Check operation.
        applyStimulus("chk_err",   3'd1, 8'h01, 4'd8,  1'b1, 1'b0, 0, 1'b0);
        applyStimulus("chk_ok",    3'd1, 8'h01, 4'd8,  1'b1, 1'b1, 0, 1'b0);

        // Backpressure.
        applyStimulus("backpress", 3'd2, 8'h3C, 4'd6,  1'b1, 1'b0, 5, 1'b0);

        // Reset during the third CALC cycle.
        mode     = 3'd1;
        data     = 8'hA5;
        data_len = 4'd8;
        chk_en   = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst     = 1'b1;
        err_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        err_clr = 1'b0;
        exp_cnt = 0;
        checkOutput("midrst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst.err_cnt",   32'(err_cnt),   32'd0);
        checkOutput("midrst.in_ready",  32'(in_ready),  32'd1);
        checkOutput("midrst.p_out",     32'(p_out),     32'd0);

        // Saturation, then a clear coinciding with a fifth error.
        for (int i = 0; i < 4; i++) begin
            applyStimulus("sat", 3'd1, 8'h03, 4'd8, 1'b1, 1'b1, 0, 1'b0);
        end
        checkOutput("sat.final", 32'(err_cnt), 32'(CNT_MAX));
        applyStimulus("sat_clr", 3'd1, 8'h03, 4'd8, 1'b1, 1'b1, 0, 1'b1);

        // A few random words.
        for (int i = 0; i < 8; i++) begin
            applyStimulus("rand", 3'($urandom_range(0, 7)), 8'($urandom),
                          4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
